// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_prefetch_queue_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ENTRY_W = 96;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetched {PC, PC+4, instruction} entries.
module prefetch_fifo
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // Storage is cleared on reset so the head fields read zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = fetch_entry_t'(mem[rd_ptr]);

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues PC-ordered memory requests and queues the returned words.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Redirect,
  input  logic [ADDR_W-1:0]      RedirectPC,
  output logic                   ImemReq,
  output logic [ADDR_W-1:0]      ImemAddr,
  input  logic                   ImemAck,
  input  logic [ADDR_W-1:0]      ImemData,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [ADDR_W-1:0]      OutInstruction,
  output logic [ADDR_W-1:0]      OutPC,
  output logic [ADDR_W-1:0]      OutPCPlus4,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_next;
  logic [ADDR_W-1:0] drop_addr, drop_addr_next;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  count_after;
  logic              req, push, pop, flush;
  fetch_entry_t      push_entry, head;

  assign redirect_pc = RedirectPC & 32'hFFFF_FFFC;

  assign push_entry.pc       = fetch_pc;
  assign push_entry.pc_plus4 = fetch_pc + 32'd4;
  assign push_entry.instr    = ImemData;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      drop_addr <= '0;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      drop_addr <= drop_addr_next;
    end
  end

  // An IDLE cycle with room issues combinationally, so its ack is handled like one in REQ.
  always_comb begin
    state_next     = state;
    fetch_pc_next  = fetch_pc;
    drop_addr_next = drop_addr;
    req            = 1'b0;
    ImemAddr       = fetch_pc;
    push           = 1'b0;
    flush          = 1'b0;
    pop            = OutValid && OutReady && !Redirect;
    count_after    = Count + CNT_W'(1) - CNT_W'(pop);
    case (state)
      IDLE: begin
        if (Redirect) begin
          fetch_pc_next = redirect_pc;
          flush         = 1'b1;
        end else if (Count < CNT_W'(DEPTH)) begin
          req        = 1'b1;
          state_next = REQ;
          if (ImemAck) begin
            push          = 1'b1;
            fetch_pc_next = fetch_pc + 32'd4;
            state_next    = (count_after < CNT_W'(DEPTH)) ? REQ : IDLE;
          end
        end
      end
      REQ: begin
        req = 1'b1;
        if (Redirect) begin
          fetch_pc_next = redirect_pc;
          flush         = 1'b1;
          if (ImemAck) begin
            state_next = IDLE;
          end else begin
            state_next     = DROP;
            drop_addr_next = fetch_pc;
          end
        end else if (ImemAck) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc + 32'd4;
          state_next    = (count_after < CNT_W'(DEPTH)) ? REQ : IDLE;
        end
      end
      DROP: begin
        req      = 1'b1;
        ImemAddr = drop_addr;
        if (Redirect) begin
          fetch_pc_next = redirect_pc;
          flush         = 1'b1;
        end
        if (ImemAck) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    ImemReq = req && !Reset;
  end

  prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst      (Reset),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (flush),
    .head     (head),
    .count    (Count)
  );

  assign OutValid       = (Count != '0);
  assign OutPC          = head.pc;
  assign OutPCPlus4     = head.pc_plus4;
  assign OutInstruction = head.instr;

endmodule
